control_unit: RTL

- Multicycle main control FSM for the RV64 datapath.
- Sits directly downstream of the instruction register. It consumes the latched instruction word and the Ula64 comparison flags.
- It drives every load/write enable and mux select of the datapath: PC, A, B, ALUOut, MDR, EPC, register bank, data memory and ALU selector.
- Implements fetch, decode and execute sequencing for the supported RV64I subset.

---
 rtl/control_unit.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: multicycle main control FSM for the RV64I datapath (fetch, decode, execute sequencing).
// Build macro CTRL_EXCEPTION_EN: invalid instructions and ALU overflow trap through EXC (EPC + trap vector).
module control_unit #(
    parameter int unsigned MEM_LATENCY     = 1,
    parameter logic [1:0]  TRAP_VECTOR_SEL = 2'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        igual,
    input  logic        maior,
    input  logic        menor,
    input  logic        overflow,
    output logic        pc_write,
    output logic        ir_load,
    output logic        mem_wr,
    output logic        a_load,
    output logic        b_load,
    output logic        aluout_load,
    output logic        mdr_load,
    output logic        reg_write,
    output logic        epc_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_sel,
    output logic [1:0]  pc_src,
    output logic [1:0]  mem_to_reg,
    output logic [4:0]  state_dbg
);

    // state        | meaning
    // ST_RST       | in reset, all outputs idle
    // ST_FETCH     | instruction read, PC+4 on last wait cycle
    // ST_DECODE    | load A/B, precompute branch/jal target
    // ST_R_EX      | register-register ALU op
    // ST_I_EX      | addi
    // ST_WB        | write ALUOut to rd
    // ST_LDST_ADDR | effective address A+imm
    // ST_LD_MEM    | wait for load data, latch MDR
    // ST_LD_WB     | write MDR to rd
    // ST_ST_MEM    | store strobe then latency wait
    // ST_BRANCH    | beq/bne compare and conditional PC write
    // ST_JAL       | rd=PC+4, PC=target
    // ST_LUI       | rd=imm
    // ST_INVALID   | unsupported instruction
    // ST_EXC       | trap: EPC write, PC=trap vector
    typedef enum logic [4:0] {
        ST_RST       = 5'd0,
        ST_FETCH     = 5'd1,
        ST_DECODE    = 5'd2,
        ST_R_EX      = 5'd3,
        ST_I_EX      = 5'd4,
        ST_WB        = 5'd5,
        ST_LDST_ADDR = 5'd6,
        ST_LD_MEM    = 5'd7,
        ST_LD_WB     = 5'd8,
        ST_ST_MEM    = 5'd9,
        ST_BRANCH    = 5'd10,
        ST_JAL       = 5'd11,
        ST_LUI       = 5'd12,
        ST_INVALID   = 5'd13,
        ST_EXC       = 5'd14
    } state_e;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_e     state_q, state_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic       wait_done;
    logic       ex_overflow;

    wire [6:0] opcode = instr[6:0];
    wire [2:0] funct3 = instr[14:12];

`ifdef CTRL_EXCEPTION_EN
    assign ex_overflow = overflow;
    logic unused_sig;
    assign unused_sig = ^{maior, menor, instr[31], instr[29:15], instr[11:7]};
`else
    assign ex_overflow = 1'b0;
    logic unused_sig;
    assign unused_sig = ^{maior, menor, overflow, TRAP_VECTOR_SEL,
                          instr[31], instr[29:15], instr[11:7]};
`endif

    assign wait_done = (wcnt_q == LAT);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RST;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Counter restarts on every state change so each multi-cycle state sees 0..LAT.
    always_comb begin
        if (state_d != state_q) begin
            wcnt_d = 3'd0;
        end else if (wait_done) begin
            wcnt_d = wcnt_q;
        end else begin
            wcnt_d = wcnt_q + 3'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_load     = 1'b0;
        mem_wr      = 1'b0;
        a_load      = 1'b0;
        b_load      = 1'b0;
        aluout_load = 1'b0;
        mdr_load    = 1'b0;
        reg_write   = 1'b0;
        epc_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_sel     = ALU_PASS;
        pc_src      = 2'd0;
        mem_to_reg  = 2'd0;

        case (state_q)
            ST_RST: state_d = ST_FETCH;

            ST_FETCH: begin
                alu_src_b = 2'd1;
                alu_sel   = ALU_ADD;
                if (wait_done) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                a_load      = 1'b1;
                b_load      = 1'b1;
                aluout_load = 1'b1;
                alu_src_b   = 2'd3;
                alu_sel     = ALU_ADD;
                case (opcode)
                    OP_R:               state_d = ST_R_EX;
                    OP_I:               state_d = ST_I_EX;
                    OP_LOAD, OP_STORE:  state_d = ST_LDST_ADDR;
                    OP_BRANCH:          state_d = ST_BRANCH;
                    OP_JAL:             state_d = ST_JAL;
                    OP_LUI:             state_d = ST_LUI;
                    default:            state_d = ST_INVALID;
                endcase
            end

            ST_R_EX: begin
                alu_src_a   = 1'b1;
                aluout_load = 1'b1;
                state_d     = ex_overflow ? ST_EXC : ST_WB;
                case (funct3)
                    3'b000:  alu_sel = instr[30] ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_sel = ALU_AND;
                    3'b100:  alu_sel = ALU_XOR;
                    default: state_d = ST_INVALID;
                endcase
            end

            ST_I_EX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'd2;
                alu_sel     = ALU_ADD;
                aluout_load = 1'b1;
                if (funct3 != 3'b000) begin
                    state_d = ST_INVALID;
                end else begin
                    state_d = ex_overflow ? ST_EXC : ST_WB;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_LDST_ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'd2;
                alu_sel     = ALU_ADD;
                aluout_load = 1'b1;
                if (funct3 != 3'b011) begin
                    state_d = ST_INVALID;
                end else if (opcode == OP_LOAD) begin
                    state_d = ST_LD_MEM;
                end else begin
                    state_d = ST_ST_MEM;
                end
            end

            ST_LD_MEM: begin
                if (wait_done) begin
                    mdr_load = 1'b1;
                    state_d  = ST_LD_WB;
                end
            end

            ST_LD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                state_d    = ST_FETCH;
            end

            ST_ST_MEM: begin
                mem_wr = (wcnt_q == 3'd0);
                if (wait_done) begin
                    state_d = ST_FETCH;
                end
            end

            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_sel   = ALU_CMP;
                state_d   = ST_FETCH;
                case (funct3)
                    3'b000: if (igual) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd1;
                    end
                    3'b001: if (!igual) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd1;
                    end
                    default: state_d = ST_INVALID;
                endcase
            end

            ST_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd2;
                pc_write   = 1'b1;
                pc_src     = 2'd1;
                state_d    = ST_FETCH;
            end

            ST_LUI: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd3;
                state_d    = ST_FETCH;
            end

`ifdef CTRL_EXCEPTION_EN
            ST_INVALID: state_d = ST_EXC;

            ST_EXC: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = TRAP_VECTOR_SEL;
                state_d   = ST_FETCH;
            end
`else
            ST_INVALID: state_d = ST_FETCH;
`endif

            default: state_d = ST_FETCH;
        endcase
    end

endmodule
